uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

- Receive side of the QLA board's UART link.
- Recovers 8N1 bytes from the PC-driven RX pin using 16x oversampled mid-bit sampling.
- Clocked from the 29.49 MHz baud clock branch.
- Holds each byte in a one-deep output buffer with a valid/ack handshake, plus sticky framing and overrun flags for the host-side register interface.

## Interface
Parameters:
- CLK_DIV, default 16: sysclk cycles per oversample tick. 29.49 MHz / 16 / 16 ≈ 115200 baud.
- OVERSAMPLE, default 16: ticks per bit. Must be even and ≥ 4.

Ports:
- sysclk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rxd  in  1  raw serial line from the USB-UART chip; idle high; asynchronous.
- rx_data  out  8  received byte; LSB received first.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ack  in  1  consumer takes the byte.
- err_clr  in  1  clears both sticky error flags.
- framing_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte was dropped because the buffer was full.
- rx_busy  out  1  FSM is not in IDLE.

## Operation
Input synchronizer:
- rxd passes through 2 flops, both reset to 1, giving rxd_s.
- The FSM only ever sees rxd_s.

Counters:
- Prescaler counts 0..CLK_DIV-1 and issues a one-cycle tick at CLK_DIV-1.
- Tick counter counts 0..OVERSAMPLE-1 and advances on tick.
- Both are forced to 0 in IDLE and on every state entry.

FSM states are IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on rxd_s == 0, go to START.
- START: at tick count OVERSAMPLE/2-1 (mid-bit), sample rxd_s.
  - 0: go to DATA with bit index 0.
  - 1: false start; go to IDLE with no flag.
- DATA: sample every OVERSAMPLE ticks.
  - Each sample shifts into bit [index], so the first bit lands in bit 0.
  - After bit 7, go to STOP.
- STOP: sample once more OVERSAMPLE ticks later.
  - 1: deliver the byte and go to IDLE.
  - 0: set framing_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s == 1, then go to IDLE. This prevents a break condition from being taken as a new start.

Output buffer, applied on the deliver cycle:
- rx_valid == 0, or rx_ack == 1 in the same cycle: load rx_data and set rx_valid = 1.
- rx_valid == 1 and rx_ack == 0: keep the old rx_data, drop the new byte, set overrun.

Buffer outside a deliver cycle:
- rx_ack while rx_valid clears rx_valid.
- rx_ack while rx_valid == 0 is ignored.
- rx_data is unchanged on ack.

Sticky flags:
- err_clr clears both flags.
- If err_clr coincides with a new error event, the set wins.

rx_busy is 1 in every state except IDLE.

## Timing
Reset values:
- rx_data = 8'h00, rx_valid = 0, framing_err = 0, overrun = 0, rx_busy = 0.
- FSM = IDLE, counters = 0, synchronizer = 1.

Reset is asynchronous and may arrive mid-frame:
- All state returns to the reset values immediately.
- The partially received byte is lost and no flag is set.
- Release is used synchronously.

Latency and sampling:
- Synchronizer latency is 2 cycles from a change on the rxd pin to rxd_s.
- The start bit is sampled (OVERSAMPLE/2)·CLK_DIV cycles after the start-detect edge (detect = the first edge where rxd_s == 0 in IDLE). With the defaults this is 128.
- The stop bit is sampled (OVERSAMPLE/2 + 9·OVERSAMPLE)·CLK_DIV cycles after detect. With the defaults this is 2432.
- rx_valid goes high on the edge following the stop sample, about 2435 cycles after the pin's start edge.

Next byte:
- The FSM is back in IDLE one cycle after the stop sample.
- A start bit arriving half a bit early (back-to-back frames with mid-stop resync) is accepted.

Tolerance:
- Total sampling drift must stay below ±4.5% of the bit period, i.e. the sum of both ends' baud error.

## Test plan
- Byte 8'hA5 at 115200 baud (bit = 256 cycles), rx_ack low:
  - rx_valid rises 2435±1 cycles after the pin start edge, with rx_data = 8'hA5.
  - rx_busy falls one cycle after the stop sample.
  - No flags set.
- Glitch low for 60 cycles, then high:
  - START samples 1 and returns to IDLE.
  - rx_valid, framing_err and overrun stay 0.
- Frame 8'h3C with the stop bit held low, line held low for another 1000 cycles, then released, then 8'h11 sent:
  - framing_err = 1 and rx_valid stays 0.
  - The FSM stays in WAIT_HIGH until release.
  - 8'h11 is then received correctly.
- Two frames 8'h01 and 8'h02 sent back to back without ack:
  - rx_data = 8'h01 and overrun = 1.
  - err_clr clears overrun.
  - rx_ack then drops rx_valid.
- Second byte 8'h55 delivered in the same cycle that rx_ack is asserted for 8'hAA:
  - rx_data = 8'h55, rx_valid stays 1, overrun stays 0.
- reset pulsed low at bit 4 of a frame:
  - All outputs return to reset values immediately.
  - The next complete frame 8'hF0 is received correctly.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive path: 8N1 deserializer with 16x-style oversampled mid-bit
// sampling, a one-deep output buffer with valid/ack handshake, and sticky
// framing / overrun flags for the host register interface.
module uart_rx_deserializer #(
  parameter int CLK_DIV    = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic       framing_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] MID_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state, state_nxt;
  logic [1:0]      sync_q;
  logic            rxd_s;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   tcnt;
  logic            tick;
  logic            sample;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_q;
  logic            deliver;
  logic            stop_bad;

  assign rxd_s = sync_q[1];
  assign tick  = (presc == PRE_LAST);

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rxd};
  end

  // State register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sample strobe: mid start bit in START, then one full bit period later.
  always_comb begin
    sample = 1'b0;
    if (tick) begin
      case (state)
        START:      sample = (tcnt == MID_LAST);
        DATA, STOP: sample = (tcnt == BIT_LAST);
        default:    sample = 1'b0;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rxd_s) state_nxt = START;
      START:     if (sample) state_nxt = rxd_s ? IDLE : DATA;
      DATA:      if (sample && bit_idx == 3'd7) state_nxt = STOP;
      STOP:      if (sample) state_nxt = rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy indicator and stop-bit outcome strobes.
  always_comb begin
    rx_busy  = (state != IDLE);
    deliver  = (state == STOP) && sample && rxd_s;
    stop_bad = (state == STOP) && sample && !rxd_s;
  end

  // Prescaler and tick counter, restarted in IDLE and on every state entry
  // so each state measures time from its own entry edge.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      tcnt  <= '0;
    end else if (state == IDLE || state_nxt != state) begin
      presc <= '0;
      tcnt  <= '0;
    end else if (tick) begin
      presc <= '0;
      tcnt  <= (tcnt == BIT_LAST) ? '0 : tcnt + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Data bits land LSB first at bit_idx; index is parked at 0 outside DATA.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      bit_idx <= 3'd0;
      shift_q <= 8'h00;
    end else if (state == DATA) begin
      if (sample) begin
        shift_q[bit_idx] <= rxd_s;
        bit_idx          <= bit_idx + 3'd1;
      end
    end else begin
      bit_idx <= 3'd0;
    end
  end

  // One-deep output buffer; an ack coinciding with delivery frees the slot.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (deliver) begin
      if (!rx_valid || rx_ack) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (stop_bad)     framing_err <= 1'b1;
      else if (err_clr) framing_err <= 1'b0;
      if (deliver && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (err_clr)                   overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed scenarios plus a randomized run
// checked against a frame-level model of the receive buffer and flags.
module tb_uart_rx_deserializer;

  localparam int CLK_DIV    = 16;
  localparam int OVERSAMPLE = 16;
  localparam int BIT        = CLK_DIV * OVERSAMPLE;
  // pin start edge -> rx_valid rise: 2 sync + 1 detect + (OS/2 + 9*OS)*CLK_DIV
  localparam int LAT        = 3 + (OVERSAMPLE / 2 + 9 * OVERSAMPLE) * CLK_DIV;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       rxd    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack  = 1'b0;
  logic       err_clr = 1'b0;
  logic       framing_err;
  logic       overrun;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;

  // Frame-level model state
  logic [7:0] exp_data;
  logic       exp_valid, exp_fe, exp_ovr;

  always #5 sysclk = ~sysclk;

  uart_rx_deserializer #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OVERSAMPLE)) dut (
    .sysclk(sysclk), .reset(reset), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .err_clr(err_clr), .framing_err(framing_err), .overrun(overrun),
    .rx_busy(rx_busy)
  );

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop slot; line left at stop_bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge sysclk); #1;
    rxd = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(BIT);
    end
    rxd = stop_bit;
    wait_cyc(BIT);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1; wait_cyc(1); rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; wait_cyc(1); err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wait_cyc(3);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    total++; if (framing_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", framing_err, overrun); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    @(negedge sysclk); reset = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_basic();
    int n = 0;
    logic prev_busy = 1'b0;
    logic seen_busy = 1'b0;
    logic busy_at_rise = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge sysclk); #1;
        while (n < LAT + 200) begin
          prev_busy = rx_busy;
          @(posedge sysclk); #1;
          n++;
          if (rx_valid) begin
            seen_busy    = prev_busy;
            busy_at_rise = rx_busy;
            break;
          end
        end
      end
    join
    total++; if (n < LAT - 1 || n > LAT + 1) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d+-1", n, LAT); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", rx_data); end
    total++; if (seen_busy !== 1'b1 || busy_at_rise !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%b->%b exp=1->0", seen_busy, busy_at_rise); end
    total++; if (framing_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b exp=00", framing_err, overrun); end
    pulse_ack();
    total++; if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin bad++; $display("FAIL basic_ack got=%b/%h exp=0/a5", rx_valid, rx_data); end
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    wait_cyc(30);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%b exp=1", rx_busy); end
    wait_cyc(30);
    rxd = 1'b1;
    wait_cyc(200);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", rx_busy); end
    total++; if (rx_valid !== 1'b0 || framing_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL glitch_flags got=%b%b%b exp=000", rx_valid, framing_err, overrun); end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    wait_cyc(1000);
    total++; if (framing_err !== 1'b1 || rx_valid !== 1'b0) begin bad++; $display("FAIL frame_err got=fe%b v%b exp=fe1 v0", framing_err, rx_valid); end
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL frame_wait_high got=%b exp=1", rx_busy); end
    rxd = 1'b1;
    wait_cyc(32);
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL frame_release got=%b exp=0", rx_busy); end
    send_frame(8'h11, 1'b1);
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin bad++; $display("FAIL frame_next got=%b/%h exp=1/11", rx_valid, rx_data); end
    total++; if (framing_err !== 1'b1) begin bad++; $display("FAIL frame_sticky got=%b exp=1", framing_err); end
    pulse_ack();
    pulse_clr();
    total++; if (framing_err !== 1'b0 || rx_valid !== 1'b0) begin bad++; $display("FAIL frame_clear got=fe%b v%b exp=fe0 v0", framing_err, rx_valid); end
  endtask

  task automatic test_overrun();
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    total++; if (rx_data !== 8'h01 || rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_data got=%b/%h exp=1/01", rx_valid, rx_data); end
    total++; if (overrun !== 1'b1 || framing_err !== 1'b0) begin bad++; $display("FAIL ovr_flag got=o%b f%b exp=o1 f0", overrun, framing_err); end
    pulse_clr();
    total++; if (overrun !== 1'b0 || rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_clr got=o%b v%b exp=o0 v1", overrun, rx_valid); end
    pulse_ack();
    total++; if (rx_valid !== 1'b0 || rx_data !== 8'h01) begin bad++; $display("FAIL ovr_ack got=%b/%h exp=0/01", rx_valid, rx_data); end
  endtask

  task automatic test_ack_same_cycle();
    send_frame(8'hAA, 1'b1);
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'hAA) begin bad++; $display("FAIL samecyc_first got=%b/%h exp=1/aa", rx_valid, rx_data); end
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge sysclk);
        repeat (LAT - 1) @(posedge sysclk);
        #1 rx_ack = 1'b1;
        @(posedge sysclk);
        #1 rx_ack = 1'b0;
      end
    join
    total++; if (rx_data !== 8'h55 || rx_valid !== 1'b1) begin bad++; $display("FAIL samecyc_data got=%b/%h exp=1/55", rx_valid, rx_data); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL samecyc_ovr got=%b exp=0", overrun); end
    pulse_ack();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       ok;
    pulse_ack();
    pulse_clr();
    exp_valid = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0; exp_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        exp_valid = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        exp_fe = 1'b0; exp_ovr = 1'b0;
      end
      send_frame(b, ok);
      if (!ok) begin
        rxd = 1'b1;
        wait_cyc(32);
      end
      // Frame-level model: a good stop either fills the buffer or is lost
      if (!ok)             exp_fe = 1'b1;
      else if (exp_valid)  exp_ovr = 1'b1;
      else begin exp_data = b; exp_valid = 1'b1; end
      total++; if (rx_valid !== exp_valid) begin bad++; $display("FAIL rand%0d_valid got=%b exp=%b", k, rx_valid, exp_valid); end
      total++; if (exp_valid && rx_data !== exp_data) begin bad++; $display("FAIL rand%0d_data got=%h exp=%h", k, rx_data, exp_data); end
      total++; if (framing_err !== exp_fe) begin bad++; $display("FAIL rand%0d_fe got=%b exp=%b", k, framing_err, exp_fe); end
      total++; if (overrun !== exp_ovr) begin bad++; $display("FAIL rand%0d_ovr got=%b exp=%b", k, overrun, exp_ovr); end
    end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] pb = 8'hC3;
    pulse_ack();
    send_frame(8'h5A, 1'b1);
    send_frame(8'h5B, 1'b1);
    total++; if (rx_valid !== 1'b1 || overrun !== 1'b1) begin bad++; $display("FAIL rst_pre got=v%b o%b exp=v1 o1", rx_valid, overrun); end
    @(posedge sysclk); #1;
    rxd = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = pb[i];
      wait_cyc(BIT);
    end
    rxd = pb[4];
    wait_cyc(BIT / 2);
    #3 reset = 1'b0;
    rxd = 1'b1;
    #1;
    total++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin bad++; $display("FAIL rst_async_buf got=%b/%h exp=0/00", rx_valid, rx_data); end
    total++; if (framing_err !== 1'b0 || overrun !== 1'b0 || rx_busy !== 1'b0) begin bad++; $display("FAIL rst_async_flags got=%b%b%b exp=000", framing_err, overrun, rx_busy); end
    wait_cyc(3);
    @(negedge sysclk); reset = 1'b1;
    wait_cyc(BIT * 2);
    total++; if (rx_valid !== 1'b0 || framing_err !== 1'b0 || rx_busy !== 1'b0) begin bad++; $display("FAIL rst_after got=%b%b%b exp=000", rx_valid, framing_err, rx_busy); end
    send_frame(8'hF0, 1'b1);
    total++; if (rx_valid !== 1'b1 || rx_data !== 8'hF0) begin bad++; $display("FAIL rst_next got=%b/%h exp=1/f0", rx_valid, rx_data); end
    total++; if (framing_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL rst_next_flags got=%b%b exp=00", framing_err, overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_ack_same_cycle();
    test_random();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
